// File: rtl/uart_pkg.sv
// uart_pkg: capture-FSM state encodings and byte width shared by the UART receive path
package uart_pkg;
  localparam int BYTE_W = 8;
  localparam logic [1:0] CAP_IDLE = 2'd0;
  localparam logic [1:0] CAP_ARM  = 2'd1;
  localparam logic [1:0] CAP_HOLD = 2'd2;
endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: W x DEPTH register array, sync write (clk, we, waddr, wdata), async read (raddr -> rdata), no reset
module uart_fifo_mem #(
  parameter int W = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: one push per recv_valid pulse into an FWFT FIFO read via rd_valid/rd_ready, with level/full/empty/sticky overflow; UART_RX_FIFO_BREAK_EN stores recv_break and adds rd_break
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              recv_valid,
  input  logic [BYTE_W-1:0] recv_data,
  input  logic              recv_break,
  input  logic              flush,
  input  logic              clr_overflow,
  input  logic              rd_ready,
`ifdef UART_RX_FIFO_BREAK_EN
  output logic              rd_break,
`endif
  output logic              rd_valid,
  output logic [BYTE_W-1:0] rd_data,
  output logic [AW:0]       level,
  output logic              full,
  output logic              empty,
  output logic              overflow
);
`ifdef UART_RX_FIFO_BREAK_EN
  localparam int W = BYTE_W + 1;
  logic [W-1:0] wdata;
  assign wdata = {recv_break, recv_data};
`else
  localparam int W = BYTE_W;
  logic [W-1:0] wdata;
  logic unused_break;
  assign wdata = recv_data;
  assign unused_break = recv_break;
`endif
  logic [1:0] cap_state;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [W-1:0] head;
  logic push, pop, wr, rd, drop;
  assign push = cap_state == CAP_ARM && recv_valid;
  assign pop = rd_valid & rd_ready;
  assign wr = push & (!full | pop) & !flush;
  assign rd = pop & !flush;
  assign drop = push & full & !pop & !flush;
  assign empty = level == '0;
  assign full = level == (AW+1)'(DEPTH);
  assign rd_valid = !empty;
  assign rd_data = rd_valid ? head[BYTE_W-1:0] : '0;
`ifdef UART_RX_FIFO_BREAK_EN
  assign rd_break = rd_valid & head[BYTE_W];
`endif
  always_ff @(posedge clk) begin
    cap_state <= reset || !recv_valid ? CAP_IDLE : cap_state == CAP_IDLE ? CAP_ARM : CAP_HOLD;
    wr_ptr <= reset || flush ? '0 : wr_ptr + AW'(wr);
    rd_ptr <= reset || flush ? '0 : rd_ptr + AW'(rd);
    level <= reset || flush ? '0 : level + (AW+1)'(wr) - (AW+1)'(rd);
    overflow <= !reset & (drop | (overflow & !clr_overflow));
  end
  uart_fifo_mem #(.W(W), .DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .we(wr),
    .waddr(wr_ptr),
    .wdata(wdata),
    .raddr(rd_ptr),
    .rdata(head)
  );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed scoreboard bench for uart_rx_fifo with DEPTH=4
module tb_uart_rx_fifo;
  logic clk = 0, reset = 1, recv_valid = 0, recv_break = 0, flush = 0, clr_overflow = 0, rd_ready = 0;
  logic [7:0] recv_data = 0;
  logic rd_valid, full, empty, overflow, brk_obs;
  logic [7:0] rd_data;
  logic [2:0] level;
  logic [8:0] exp_q[$];
  logic [8:0] e;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
`ifdef UART_RX_FIFO_BREAK_EN
  logic rd_break;
  assign brk_obs = rd_break;
`else
  assign brk_obs = 1'b0;
`endif
  uart_rx_fifo #(.DEPTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .recv_valid(recv_valid),
    .recv_data(recv_data),
    .recv_break(recv_break),
    .flush(flush),
    .clr_overflow(clr_overflow),
    .rd_ready(rd_ready),
`ifdef UART_RX_FIFO_BREAK_EN
    .rd_break(rd_break),
`endif
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .level(level),
    .full(full),
    .empty(empty),
    .overflow(overflow)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] d, input logic brk, input bit keep);
    recv_valid = 1;
    recv_data = ~d;
    recv_break = ~brk;
    tick();
    recv_data = d;
    recv_break = brk;
    tick();
    tick();
    recv_valid = 0;
    tick();
`ifdef UART_RX_FIFO_BREAK_EN
    if (keep) exp_q.push_back({brk, d});
`else
    if (keep) exp_q.push_back({1'b0, d});
`endif
  endtask
  task automatic read_one(input string tag);
    check({tag, "_valid"}, rd_valid, 1);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_data"}, rd_data, e[7:0]);
      check({tag, "_break"}, brk_obs, e[8]);
    end
    rd_ready = 1;
    tick();
    rd_ready = 0;
  endtask
  initial begin
    tick();
    tick();
    reset = 0;
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_brk", brk_obs, 0);
    check("rst_level", level, 0);
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_overflow", overflow, 0);
    recv_valid = 1;
    recv_data = 8'h00;
    tick();
    check("single_no_push_yet", level, 0);
    recv_data = 8'hA5;
    tick();
    check("single_latency_valid", rd_valid, 1);
    check("single_latency_data", rd_data, 8'hA5);
    repeat (18) tick();
    recv_valid = 0;
    tick();
    check("single_level", level, 1);
    exp_q.push_back(9'h0A5);
    read_one("single_rd");
    check("single_drained", rd_valid, 0);
    recv_valid = 1;
    tick();
    recv_valid = 0;
    tick();
    tick();
    check("glitch_level", level, 0);
    recv_valid = 1;
    tick();
    recv_valid = 0;
    tick();
    check("glitch_idle", level, 0);
    for (int i = 1; i <= 5; i++) send(8'(i), 0, i <= 4);
    check("fill_full", full, 1);
    check("fill_level", level, 4);
    check("fill_overflow", overflow, 1);
    for (int i = 0; i < 4; i++) read_one("fill_rd");
    check("fill_empty_valid", rd_valid, 0);
    check("fill_empty", empty, 1);
    check("fill_ovf_sticky", overflow, 1);
    clr_overflow = 1;
    tick();
    clr_overflow = 0;
    check("ovf_cleared", overflow, 0);
    for (int i = 0; i < 4; i++) send(8'h11 + 8'(i), 0, 1);
    check("pp_full", full, 1);
    recv_valid = 1;
    recv_data = 8'hEF;
    tick();
    recv_data = 8'h10;
    rd_ready = 1;
    e = exp_q.pop_front();
    check("pp_head", rd_data, e[7:0]);
    tick();
    rd_ready = 0;
    recv_valid = 0;
    exp_q.push_back(9'h010);
    tick();
    check("pp_level", level, 4);
    check("pp_overflow", overflow, 0);
    for (int i = 0; i < 4; i++) read_one("pp_rd");
    for (int i = 0; i < 3; i++) send(8'h21 + 8'(i), 0, 0);
    check("flush_pre_level", level, 3);
    recv_valid = 1;
    tick();
    recv_data = 8'h24;
    flush = 1;
    tick();
    flush = 0;
    recv_valid = 0;
    tick();
    check("flush_level", level, 0);
    check("flush_empty", empty, 1);
    check("flush_overflow", overflow, 0);
    send(8'h30, 0, 1);
    read_one("post_flush_rd");
    for (int i = 0; i < 4; i++) send(8'h41 + 8'(i), 0, 1);
    recv_valid = 1;
    tick();
    recv_data = 8'h45;
    clr_overflow = 1;
    tick();
    clr_overflow = 0;
    recv_valid = 0;
    tick();
    check("set_wins_overflow", overflow, 1);
    check("set_wins_level", level, 4);
    clr_overflow = 1;
    tick();
    clr_overflow = 0;
    check("clr_overflow", overflow, 0);
    for (int i = 0; i < 4; i++) read_one("sw_rd");
    recv_valid = 1;
    recv_data = 8'h66;
    tick();
    reset = 1;
    tick();
    reset = 0;
    tick();
    check("midrst_no_push", level, 0);
    tick();
    check("midrst_push", level, 1);
    recv_valid = 0;
    tick();
    exp_q.push_back(9'h066);
    read_one("midrst_rd");
    send(8'h00, 1, 1);
    send(8'h3C, 0, 1);
    read_one("brk_rd");
    read_one("norm_rd");
    check("final_empty", empty, 1);
    check("final_sb", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
